// File: rtl/fsk_rx_ctrl.sv
// FSK receive controller: hunts for a sync word on the demodulated bit
// stream, reads a length byte, then delivers payload bytes over a
// valid/ready handshake with sticky overflow on byte loss.
module fsk_rx_ctrl #(
    parameter logic [7:0] SYNC_WORD = 8'hA7,
    parameter int         HUNT_MAX  = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       demod_en,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic       overflow
);

    localparam logic [8:0] HUNT_LIMIT = 9'(HUNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] sync_q, sync_d;
    logic [8:0] hunt_q, hunt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] remain_q, remain_d;
    logic [7:0] byte_out_q, byte_out_d;
    logic       byte_valid_q, byte_valid_d;
    logic       overflow_q, overflow_d;
    logic       timeout_q, timeout_d;

    // Candidate values after accepting the current bit.
    logic [7:0] sync_shifted;
    logic [7:0] data_shifted;
    logic [8:0] hunt_inc;
    assign sync_shifted = {sync_q[6:0], bit_in};
    assign data_shifted = {shift_q[6:0], bit_in};
    assign hunt_inc     = hunt_q + 9'd1;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            sync_q       <= 8'h00;
            hunt_q       <= 9'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            remain_q     <= 8'h00;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            hunt_q       <= hunt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            remain_q     <= remain_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
        end
    end

    // Next-state, bit collection and byte handshake logic.
    always_comb begin
        state_d      = state_q;
        sync_d       = sync_q;
        hunt_d       = hunt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        remain_d     = remain_q;
        byte_out_d   = byte_out_q;
        // A pending byte drops once the consumer takes it.
        byte_valid_d = byte_valid_q & ~byte_ready;
        overflow_d   = overflow_q;
        timeout_d    = 1'b0;

        if (abort) begin
            // Abort beats everything, including a simultaneous start.
            state_d      = S_IDLE;
            byte_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d    = S_HUNT;
                        sync_d     = 8'h00;
                        hunt_d     = 9'd0;
                        bit_cnt_d  = 3'd0;
                        shift_d    = 8'h00;
                        overflow_d = 1'b0;
                    end
                end
                S_HUNT: begin
                    if (bit_valid) begin
                        sync_d = sync_shifted;
                        hunt_d = hunt_inc;
                        // A match on the final strobe still wins over timeout.
                        if (sync_shifted == SYNC_WORD) begin
                            state_d   = S_LEN;
                            bit_cnt_d = 3'd0;
                        end else if (hunt_inc == HUNT_LIMIT) begin
                            state_d   = S_IDLE;
                            timeout_d = 1'b1;
                        end
                    end
                end
                S_LEN: begin
                    if (bit_valid) begin
                        shift_d   = data_shifted;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            remain_d = data_shifted;
                            state_d  = (data_shifted != 8'h00) ? S_PAYLOAD : S_DONE;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (bit_valid) begin
                        shift_d   = data_shifted;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            // Output slot is free if empty or being drained now.
                            if (!byte_valid_q || byte_ready) begin
                                byte_out_d   = data_shifted;
                                byte_valid_d = 1'b1;
                            end else begin
                                overflow_d = 1'b1;
                            end
                            remain_d = remain_q - 8'd1;
                            if (remain_q == 8'd1) begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign demod_en   = (state_q == S_HUNT) || (state_q == S_LEN) || (state_q == S_PAYLOAD);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign timeout    = timeout_q;
    assign overflow   = overflow_q;
    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;

endmodule

// File: tb/tb_fsk_rx_ctrl.sv
// Directed self-checking bench for fsk_rx_ctrl.
module tb_fsk_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       byte_ready = 1'b0;
    logic       demod_en;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       busy;
    logic       done;
    logic       timeout;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // Monitor-owned records of accepted bytes and pulses.
    logic [7:0] rx_bytes [0:15];
    int rx_count = 0;
    int done_total = 0;
    int timeout_total = 0;

    int base_rx;
    int base_done;
    int base_to;

    fsk_rx_ctrl #(.SYNC_WORD(8'hA7), .HUNT_MAX(256)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .bit_in(bit_in), .bit_valid(bit_valid), .demod_en(demod_en),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy), .done(done), .timeout(timeout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Sample on the falling edge: record handshakes and pulses.
    always @(negedge clk) begin
        if (rst && byte_valid && byte_ready) begin
            rx_bytes[rx_count[3:0]] <= byte_out;
            rx_count <= rx_count + 1;
        end
        if (done) done_total <= done_total + 1;
        if (timeout) timeout_total <= timeout_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_demod_en"}, {31'd0, demod_en}, 32'd0);
        check({tag, "_byte_valid"}, {31'd0, byte_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
        check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        check({tag, "_byte_out"}, {24'd0, byte_out}, 32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst0");
        rst = 1'b1;
        tick();

        // Normal frame: preamble, sync, length 3, payload 11 22 33
        byte_ready = 1'b1;
        base_rx = rx_count;
        base_done = done_total;
        pulse_start();
        check("f1_busy_after_start", {31'd0, busy}, 32'd1);
        check("f1_demod_en_hunt", {31'd0, demod_en}, 32'd1);
        send_byte(8'h55);
        send_byte(8'hA7);
        send_byte(8'h03);
        send_byte(8'h11);
        check("f1_byte0_latency", {31'd0, byte_valid}, 32'd1);
        check("f1_byte0_value", {24'd0, byte_out}, 32'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("f1_done_pulse", {31'd0, done}, 32'd1);
        check("f1_demod_en_done", {31'd0, demod_en}, 32'd0);
        tick();
        check("f1_done_one_cycle", {31'd0, done}, 32'd0);
        check("f1_idle", {31'd0, busy}, 32'd0);
        check("f1_byte_count", rx_count - base_rx, 32'd3);
        check("f1_rx0", {24'd0, rx_bytes[base_rx]}, 32'h11);
        check("f1_rx1", {24'd0, rx_bytes[base_rx + 1]}, 32'h22);
        check("f1_rx2", {24'd0, rx_bytes[base_rx + 2]}, 32'h33);
        check("f1_done_count", done_total - base_done, 32'd1);
        check("f1_overflow", {31'd0, overflow}, 32'd0);
        check("f1_valid_dropped", {31'd0, byte_valid}, 32'd0);

        // Hunt timeout: 256 alternating bits with no sync word
        base_to = timeout_total;
        pulse_start();
        for (int i = 0; i < 255; i++) send_bit(i[0]);
        check("to_still_hunting", {31'd0, busy}, 32'd1);
        check("to_no_early_timeout", {31'd0, timeout}, 32'd0);
        send_bit(1'b1);
        check("to_timeout_pulse", {31'd0, timeout}, 32'd1);
        check("to_idle", {31'd0, busy}, 32'd0);
        check("to_demod_off", {31'd0, demod_en}, 32'd0);
        tick();
        check("to_pulse_one_cycle", {31'd0, timeout}, 32'd0);
        check("to_count", timeout_total - base_to, 32'd1);

        // Zero-length frame
        base_rx = rx_count;
        base_done = done_total;
        pulse_start();
        send_byte(8'hA7);
        send_byte(8'h00);
        check("z_done_pulse", {31'd0, done}, 32'd1);
        check("z_no_valid", {31'd0, byte_valid}, 32'd0);
        tick();
        check("z_idle", {31'd0, busy}, 32'd0);
        check("z_no_bytes", rx_count - base_rx, 32'd0);
        check("z_done_count", done_total - base_done, 32'd1);

        // Overflow: consumer stalled for the whole frame
        byte_ready = 1'b0;
        base_rx = rx_count;
        base_done = done_total;
        pulse_start();
        send_byte(8'hA7);
        send_byte(8'h02);
        send_byte(8'hAA);
        check("ov_first_valid", {31'd0, byte_valid}, 32'd1);
        check("ov_first_value", {24'd0, byte_out}, 32'hAA);
        check("ov_not_yet", {31'd0, overflow}, 32'd0);
        send_byte(8'h55);
        check("ov_held_value", {24'd0, byte_out}, 32'hAA);
        check("ov_sticky_set", {31'd0, overflow}, 32'd1);
        check("ov_done_pulse", {31'd0, done}, 32'd1);
        tick();
        check("ov_pending_in_idle", {31'd0, byte_valid}, 32'd1);
        check("ov_stays_set", {31'd0, overflow}, 32'd1);
        byte_ready = 1'b1;
        tick();
        check("ov_drained", {31'd0, byte_valid}, 32'd0);
        check("ov_rx_count", rx_count - base_rx, 32'd1);
        check("ov_rx_value", {24'd0, rx_bytes[base_rx]}, 32'hAA);

        // Abort during payload, coincident with a start pulse
        byte_ready = 1'b0;
        base_done = done_total;
        pulse_start();
        check("ab_overflow_cleared", {31'd0, overflow}, 32'd0);
        send_byte(8'hA7);
        send_byte(8'h02);
        send_byte(8'hAA);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("ab_idle", {31'd0, busy}, 32'd0);
        check("ab_valid_cleared", {31'd0, byte_valid}, 32'd0);
        check("ab_no_done", {31'd0, done}, 32'd0);
        check("ab_demod_off", {31'd0, demod_en}, 32'd0);
        tick();
        check("ab_start_ignored", {31'd0, busy}, 32'd0);
        check("ab_no_done_count", done_total - base_done, 32'd0);
        byte_ready = 1'b1;
        base_rx = rx_count;
        pulse_start();
        send_byte(8'hA7);
        send_byte(8'h01);
        send_byte(8'h3C);
        check("ab_clean_done", {31'd0, done}, 32'd1);
        tick();
        check("ab_clean_count", rx_count - base_rx, 32'd1);
        check("ab_clean_value", {24'd0, rx_bytes[base_rx]}, 32'h3C);

        // Reset in the middle of the length byte
        base_done = done_total;
        pulse_start();
        send_byte(8'hA7);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b0;
        tick();
        check_reset_outputs("mrst");
        rst = 1'b1;
        tick();
        check("mrst_no_done", done_total - base_done, 32'd0);
        base_rx = rx_count;
        pulse_start();
        send_byte(8'hA7);
        send_byte(8'h01);
        send_byte(8'h5C);
        check("mrst_done", {31'd0, done}, 32'd1);
        tick();
        check("mrst_rx_count", rx_count - base_rx, 32'd1);
        check("mrst_rx_value", {24'd0, rx_bytes[base_rx]}, 32'h5C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
